// File: rtl/flag_stack.sv
// Status-flag register with a DEPTH-entry shadow stack for nested interrupts.
// Define FLAG_STACK_WRAP_EN to make a push on a full stack discard the oldest entry.
module flag_stack #(
  parameter int N_FLAGS = 2,
  parameter int DEPTH   = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [N_FLAGS-1:0]           FLG_CLR,
  input  logic [N_FLAGS-1:0]           FLG_SET,
  input  logic [N_FLAGS-1:0]           FLG_LD,
  input  logic [N_FLAGS-1:0]           FLG_IN,
  input  logic                         FLG_PUSH,
  input  logic                         FLG_POP,
  input  logic                         ERR_CLR,
  output logic [N_FLAGS-1:0]           FLAGS_OUT,
  output logic [$clog2(DEPTH+1)-1:0]   STK_CNT,
  output logic                         STK_EMPTY,
  output logic                         STK_FULL,
  output logic                         STK_ERR
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef FLAG_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [N_FLAGS-1:0] stack [0:(1<<AW)-1];
  logic [AW-1:0]      top_idx;
  logic [AW-1:0]      wr_idx;
  logic [N_FLAGS-1:0] top;
  logic [N_FLAGS-1:0] flags_d;
  logic [CW-1:0]      cnt_d;
  logic               err_d;
  logic               empty, full, pop_ok, swap, push_new, push_wrap, push_drop, pop_only, underflow;

  assign top_idx = AW'(STK_CNT - 1'b1);
  assign wr_idx  = AW'(STK_CNT);

  always_comb begin
    empty     = (STK_CNT == '0);
    full      = (STK_CNT == CW'(DEPTH));
    pop_ok    = FLG_POP && !empty;
    swap      = FLG_PUSH && pop_ok;
    push_new  = FLG_PUSH && !pop_ok && !full;
    push_wrap = FLG_PUSH && !pop_ok && full && WRAP;
    push_drop = FLG_PUSH && !pop_ok && full && !WRAP;
    pop_only  = pop_ok && !FLG_PUSH;
    // push+pop on an empty stack degrades to a plain push, so it is not an underflow
    underflow = FLG_POP && !FLG_PUSH && empty;
    top       = stack[top_idx];

    flags_d = FLAGS_OUT;
    for (int i = 0; i < N_FLAGS; i++) begin
      if (FLG_CLR[i])      flags_d[i] = 1'b0;
      else if (FLG_SET[i]) flags_d[i] = 1'b1;
      else if (pop_ok)     flags_d[i] = top[i];
      else if (FLG_LD[i])  flags_d[i] = FLG_IN[i];
    end

    cnt_d = STK_CNT;
    if (push_new)      cnt_d = STK_CNT + 1'b1;
    else if (pop_only) cnt_d = STK_CNT - 1'b1;

    err_d = STK_ERR;
    if (underflow || push_drop) err_d = 1'b1;
    else if (ERR_CLR)           err_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      FLAGS_OUT <= '0;
      STK_CNT   <= '0;
      STK_EMPTY <= 1'b1;
      STK_FULL  <= 1'b0;
      STK_ERR   <= 1'b0;
    end else begin
      FLAGS_OUT <= flags_d;
      STK_CNT   <= cnt_d;
      STK_EMPTY <= (cnt_d == '0);
      STK_FULL  <= (cnt_d == CW'(DEPTH));
      STK_ERR   <= err_d;
    end
  end

  // Storage is never reset; writes are suppressed while reset is asserted.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      if (swap) begin
        stack[top_idx] <= FLAGS_OUT;
      end else if (push_new) begin
        stack[wr_idx] <= FLAGS_OUT;
      end else if (push_wrap) begin
        for (int k = 0; k < DEPTH-1; k++) stack[AW'(k)] <= stack[AW'(k+1)];
        stack[AW'(DEPTH-1)] <= FLAGS_OUT;
      end
    end
  end

endmodule

// File: tb/tb_flag_stack.sv
// Directed + random bench for flag_stack: queue-based reference model feeds a scoreboard.
// Honours FLAG_STACK_WRAP_EN to select the full-stack expectations.
module tb_flag_stack;

`ifdef FLAG_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] flg_clr, flg_set, flg_ld, flg_in;
  logic       flg_push, flg_pop, err_clr;
  logic [1:0] flags_out;
  logic [2:0] stk_cnt;
  logic       stk_empty, stk_full, stk_err;

  logic [3:0] clr4, set4, ld4, in4;
  logic [3:0] flags4;
  logic [2:0] cnt4;
  logic       empty4, full4, err4;

  flag_stack #(.N_FLAGS(2), .DEPTH(D)) dut (
    .CLK(clk), .RST_N(rst_n), .FLG_CLR(flg_clr), .FLG_SET(flg_set), .FLG_LD(flg_ld),
    .FLG_IN(flg_in), .FLG_PUSH(flg_push), .FLG_POP(flg_pop), .ERR_CLR(err_clr),
    .FLAGS_OUT(flags_out), .STK_CNT(stk_cnt), .STK_EMPTY(stk_empty), .STK_FULL(stk_full),
    .STK_ERR(stk_err));

  flag_stack #(.N_FLAGS(4), .DEPTH(D)) dut4 (
    .CLK(clk), .RST_N(rst_n), .FLG_CLR(clr4), .FLG_SET(set4), .FLG_LD(ld4),
    .FLG_IN(in4), .FLG_PUSH(1'b0), .FLG_POP(1'b0), .ERR_CLR(1'b0),
    .FLAGS_OUT(flags4), .STK_CNT(cnt4), .STK_EMPTY(empty4), .STK_FULL(full4),
    .STK_ERR(err4));

  typedef struct {
    string      tag;
    logic [1:0] flags;
    logic [2:0] cnt;
    logic       empty, full, err;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] m_flags = '0;
  logic [1:0] m_stk[$];
  logic       m_err = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [1:0] nf, tp;
    logic       emp, popv, newerr;
    if (!rst_n) begin
      m_flags = '0;
      m_stk.delete();
      m_err = 1'b0;
      return;
    end
    emp  = (m_stk.size() == 0);
    popv = flg_pop && !emp;
    tp   = emp ? 2'b00 : m_stk[m_stk.size()-1];
    nf   = m_flags;
    for (int i = 0; i < 2; i++)
      nf[i] = flg_clr[i] ? 1'b0 : flg_set[i] ? 1'b1 : popv ? tp[i] : flg_ld[i] ? flg_in[i] : m_flags[i];
    newerr = 1'b0;
    if (flg_push && popv) m_stk[m_stk.size()-1] = m_flags;
    else if (flg_push) begin
      if (m_stk.size() < D) m_stk.push_back(m_flags);
      else if (WRAP) begin
        void'(m_stk.pop_front());
        m_stk.push_back(m_flags);
      end else newerr = 1'b1;
    end else if (flg_pop) begin
      if (!emp) void'(m_stk.pop_back());
      else newerr = 1'b1;
    end
    m_err   = newerr ? 1'b1 : err_clr ? 1'b0 : m_err;
    m_flags = nf;
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".flags"}, 8'(flags_out), 8'(e.flags));
    chk({e.tag, ".cnt"},   8'(stk_cnt),   8'(e.cnt));
    chk({e.tag, ".empty"}, 8'(stk_empty), 8'(e.empty));
    chk({e.tag, ".full"},  8'(stk_full),  8'(e.full));
    chk({e.tag, ".err"},   8'(stk_err),   8'(e.err));
  endtask

  task automatic cyc(input string tag, input logic rst, input logic [1:0] clr, input logic [1:0] set,
                     input logic [1:0] ld, input logic [1:0] in, input logic push, input logic pop,
                     input logic eclr);
    exp_t e;
    rst_n = rst; flg_clr = clr; flg_set = set; flg_ld = ld; flg_in = in;
    flg_push = push; flg_pop = pop; err_clr = eclr;
    model_step();
    e.tag = tag; e.flags = m_flags; e.cnt = 3'(m_stk.size());
    e.empty = (m_stk.size() == 0); e.full = (m_stk.size() == D); e.err = m_err;
    sb.push_back(e);
    @(posedge clk); #1;
    check_out();
  endtask

  logic [1:0] pv[5];
  logic [1:0] pexp[4];

  initial begin
    clr4 = '0; set4 = '0; ld4 = '0; in4 = '0;
    pv[0] = 2'd1; pv[1] = 2'd2; pv[2] = 2'd3; pv[3] = 2'd0; pv[4] = 2'd1;
    if (WRAP) begin
      pexp[0] = 2'd1; pexp[1] = 2'd0; pexp[2] = 2'd3; pexp[3] = 2'd2;
    end else begin
      pexp[0] = 2'd0; pexp[1] = 2'd3; pexp[2] = 2'd2; pexp[3] = 2'd1;
    end
    @(posedge clk); #1;

    cyc("rst0", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rst1", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_flags", 8'(flags_out), 8'h0);
    chk("rst_empty", 8'(stk_empty), 8'h1);
    chk("n4_rst", 8'(flags4), 8'h0);

    clr4 = 4'b0001; set4 = 4'b0011; ld4 = 4'b1111; in4 = 4'b1000;
    cyc("set11", 1, 0, 2'b11, 0, 0, 0, 0, 0);
    chk("n4_prio", 8'(flags4), 8'h0A);
    chk("tp_set11", 8'(flags_out), 8'h3);
    clr4 = '0; set4 = '0; ld4 = '0; in4 = '0;
    cyc("rst_set", 0, 0, 2'b11, 0, 0, 0, 0, 0);
    chk("tp_rst_over_set", 8'(flags_out), 8'h0);

    cyc("f01",   1, 0, 2'b01, 0, 0, 0, 0, 0);
    cyc("push1", 1, 0, 0, 0, 0, 1, 0, 0);
    cyc("ld10",  1, 0, 0, 2'b11, 2'b10, 0, 0, 0);
    cyc("push2", 1, 0, 0, 0, 0, 1, 0, 0);
    chk("tp_cnt2", 8'(stk_cnt), 8'h2);
    cyc("ld00",  1, 0, 0, 2'b11, 2'b00, 0, 0, 0);
    cyc("pop1",  1, 0, 0, 0, 0, 0, 1, 0);
    chk("tp_pop1", 8'(flags_out), 8'h2);
    cyc("pop2",  1, 0, 0, 0, 0, 0, 1, 0);
    chk("tp_pop2", 8'(flags_out), 8'h1);
    chk("tp_pop2_err", 8'(stk_err), 8'h0);

    cyc("under", 1, 0, 0, 2'b11, 2'b10, 0, 1, 0);
    chk("tp_under_flags", 8'(flags_out), 8'h2);
    chk("tp_under_err", 8'(stk_err), 8'h1);
    cyc("errclr", 1, 0, 0, 0, 0, 0, 0, 1);
    chk("tp_errclr", 8'(stk_err), 8'h0);
    cyc("err_race", 1, 0, 0, 0, 0, 0, 1, 1);
    chk("tp_err_race", 8'(stk_err), 8'h1);
    cyc("errclr2", 1, 0, 0, 0, 0, 0, 0, 1);

    cyc("ld10b",  1, 0, 0, 2'b11, 2'b10, 0, 0, 0);
    cyc("push3",  1, 0, 0, 0, 0, 1, 0, 0);
    cyc("ld01",   1, 0, 0, 2'b11, 2'b01, 0, 0, 0);
    cyc("swap",   1, 2'b10, 0, 0, 0, 1, 1, 0);
    chk("tp_swap_flags", 8'(flags_out), 8'h0);
    chk("tp_swap_cnt", 8'(stk_cnt), 8'h1);
    cyc("swap_pop", 1, 0, 0, 0, 0, 0, 1, 0);
    chk("tp_swap_top", 8'(flags_out), 8'h1);
    cyc("pp_empty", 1, 0, 0, 0, 0, 1, 1, 0);
    chk("tp_pp_empty_err", 8'(stk_err), 8'h0);
    chk("tp_pp_empty_cnt", 8'(stk_cnt), 8'h1);
    cyc("drain", 1, 0, 0, 0, 0, 0, 1, 0);

    for (int v = 0; v < 5; v++) begin
      cyc("fill_ld", 1, 0, 0, 2'b11, pv[v], 0, 0, 0);
      cyc("fill_push", 1, 0, 0, 0, 0, 1, 0, 0);
    end
    chk("tp_full_err", 8'(stk_err), WRAP ? 8'h0 : 8'h1);
    chk("tp_full_flag", 8'(stk_full), 8'h1);
    for (int p = 0; p < 4; p++) begin
      cyc("full_pop", 1, 0, 0, 0, 0, 0, 1, 0);
      chk($sformatf("tp_full_pop%0d", p), 8'(flags_out), 8'(pexp[p]));
    end

    for (int r = 0; r < 400; r++) begin
      cyc("rand", ($urandom_range(0, 40) != 0),
          ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00,
          ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00,
          2'($urandom), 2'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_stack.md
# flag_stack

Parametrised status-flag register with a multi-level shadow stack for nested interrupt support in the RAT MCU. It holds `N_FLAGS` condition flags (bit 0 = C, bit 1 = Z by convention) with per-flag clear/set/load control. It saves the full flag vector on interrupt entry (push) and restores it on return (pop). It replaces the single-level C/Z shadow scheme, which allowed only one nesting level, and sits between the ALU/control unit and the branch logic.

## Interface
Parameters:
- `N_FLAGS`, 2: number of flag bits (≥1).
- `DEPTH`, 4: shadow stack entries (≥1).

Ports:
- `CLK`  in  1  system clock; all state changes on rising edge.
- `RST_N`  in  1  synchronous, active-low reset.
- `FLG_CLR`  in  N_FLAGS  per-flag clear.
- `FLG_SET`  in  N_FLAGS  per-flag set.
- `FLG_LD`  in  N_FLAGS  per-flag load from `FLG_IN`.
- `FLG_IN`  in  N_FLAGS  new flag values from ALU.
- `FLG_PUSH`  in  1  save current flag vector to stack.
- `FLG_POP`  in  1  restore flag vector from top of stack.
- `ERR_CLR`  in  1  clear sticky `STK_ERR`.
- `FLAGS_OUT`  out  N_FLAGS  registered flag vector.
- `STK_CNT`  out  $clog2(DEPTH+1)  entries in use.
- `STK_EMPTY`  out  1  `STK_CNT == 0`.
- `STK_FULL`  out  1  `STK_CNT == DEPTH`.
- `STK_ERR`  out  1  sticky overflow/underflow indicator.

## Operation
- Per-flag next-value priority, highest first:
  1. `RST_N` = 0.
  2. `FLG_CLR[i]`.
  3. `FLG_SET[i]`.
  4. Valid pop: restore `top[i]`.
  5. `FLG_LD[i]`: load `FLG_IN[i]`.
  6. Hold.
- `FLG_LD` is ignored on cycles with a valid pop.
- Push writes the current, pre-edge `FLAGS_OUT` into slot `STK_CNT`, then increments `STK_CNT`.
- Pop reads slot `STK_CNT-1` and decrements `STK_CNT`.
- Push and pop in the same cycle with `STK_CNT` > 0 is a swap:
  - Top slot ← current `FLAGS_OUT`.
  - Flags ← old top, still subject to CLR/SET overrides.
  - `STK_CNT` unchanged.
- Push and pop in the same cycle with `STK_CNT` = 0 is treated as a push only; no error is flagged.
- Pop when empty (underflow):
  - Flags are not restored; LD/CLR/SET still apply.
  - `STK_CNT` stays 0.
  - `STK_ERR` ← 1.
- Push when full: behaviour depends on the Configuration macro.
- `STK_ERR`:
  - Sticky until `ERR_CLR` or reset.
  - If `ERR_CLR` and a new error occur in the same cycle, the new error wins and `STK_ERR` = 1.
- Stack storage is not reset and is not externally observable.

## Timing
- All outputs are registered. Effects appear one cycle after the inputs are sampled.
- Push-to-pop round trip is 2 cycles minimum: push at edge n, pop at edge n+1 restores the value saved at edge n.
- Reset values:
  - `FLAGS_OUT` = 0
  - `STK_CNT` = 0
  - `STK_EMPTY` = 1
  - `STK_FULL` = 0
  - `STK_ERR` = 0
- Reset mid-push or mid-pop discards the operation. Reset overrides every input.
- No combinational path from any input to any output.

## Configuration
- `FLAG_STACK_WRAP_EN` defined: push when full discards the oldest entry, shifts the stack down, and writes the new entry at the top.
  - `STK_CNT` stays `DEPTH`.
  - `STK_ERR` is not set.
- `FLAG_STACK_WRAP_EN` undefined: push when full is dropped.
  - Stack and `STK_CNT` are unchanged.
  - `STK_ERR` ← 1.
  - Flag updates from CLR/SET/LD still apply.

## Test plan
- Reset, then `FLG_SET` = 2'b11 → `FLAGS_OUT` = 2'b11 next cycle. Assert `RST_N` = 0 with `FLG_SET` = 2'b11 → `FLAGS_OUT` = 0, `STK_CNT` = 0.
- Flags = 2'b01: push; load `FLG_IN` = 2'b10; push; load 2'b00; pop → 2'b10; pop → 2'b01. After both pops: `STK_EMPTY` = 1, `STK_ERR` = 0.
- Pop when empty with `FLG_LD` = 2'b11, `FLG_IN` = 2'b10 → `FLAGS_OUT` = 2'b10 and `STK_ERR` = 1. Then `ERR_CLR` → `STK_ERR` = 0.
- Flags = 2'b01, top = 2'b10: push + pop + `FLG_CLR` = 2'b10 in one cycle → `FLAGS_OUT` = 2'b00, top = 2'b01, `STK_CNT` unchanged.
- `DEPTH` = 4: push 5 times with flags 1, 2, 3, 0, 1.
  - Without `FLAG_STACK_WRAP_EN`: `STK_ERR` = 1, then 4 pops return 0, 3, 2, 1.
  - With `FLAG_STACK_WRAP_EN`: `STK_ERR` = 0, then 4 pops return 1, 0, 3, 2.
- `N_FLAGS` = 4, `FLG_CLR` = 4'b0001, `FLG_SET` = 4'b0011, `FLG_LD` = 4'b1111, `FLG_IN` = 4'b1000 → `FLAGS_OUT` = 4'b1010.
